// File: rtl/ddr_axi_arbiter.sv
// ddr_axi_arbiter: shares one DDR3 controller AXI-like port between two
// masters. Write and read paths each have their own round-robin arbiter and
// allow one outstanding burst. Optional beat-count checking is compiled in
// with the ARB_BEAT_CHECK_EN macro.
module ddr_axi_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 256,
    parameter int STRB_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  ddrphy_clkin,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] m0_awaddr,
    input  logic [LEN_WIDTH-1:0]  m0_awlen,
    input  logic                  m0_awvalid,
    output logic                  m0_awready,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [STRB_WIDTH-1:0] m0_wstrb,
    output logic                  m0_wready,
    output logic                  m0_wlast,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [LEN_WIDTH-1:0]  m0_arlen,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_rvalid,
    output logic                  m0_rlast,
    input  logic [ADDR_WIDTH-1:0] m1_awaddr,
    input  logic [LEN_WIDTH-1:0]  m1_awlen,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [STRB_WIDTH-1:0] m1_wstrb,
    output logic                  m1_wready,
    output logic                  m1_wlast,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [LEN_WIDTH-1:0]  m1_arlen,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_rvalid,
    output logic                  m1_rlast,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic [LEN_WIDTH-1:0]  axi_awlen,
    output logic                  axi_awvalid,
    output logic [3:0]            axi_awuser_id,
    output logic                  axi_awuser_ap,
    input  logic                  axi_awready,
    output logic [DATA_WIDTH-1:0] axi_wdata,
    output logic [STRB_WIDTH-1:0] axi_wstrb,
    input  logic                  axi_wready,
    input  logic                  axi_wusero_last,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [LEN_WIDTH-1:0]  axi_arlen,
    output logic                  axi_arvalid,
    output logic [3:0]            axi_aruser_id,
    output logic                  axi_aruser_ap,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [3:0]            axi_rid,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic [1:0]            err_flag
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2} arb_state_t;

    // Round-robin pick: 0 = m0, 1 = m1; ptr names the master favoured on a tie.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic ptr);
        logic pick;
        if (req0 && req1) begin
            pick = ptr;
        end else if (req1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

    arb_state_t            wr_state_q, wr_state_d, rd_state_q, rd_state_d;
    logic                  wr_gnt_q, wr_gnt_d, wr_ptr_q, wr_ptr_d;
    logic                  rd_gnt_q, rd_gnt_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [LEN_WIDTH-1:0]  awlen_q, awlen_d, arlen_q, arlen_d;
    logic [1:0]            err_q, err_d;
    logic                  wr_beat_err_s, rd_beat_err_s, rd_id_err_s;
    logic                  unused_rid_s;

    // Only the low two id bits carry the master index.
    assign unused_rid_s = ^axi_rid[3:2];

    // Write path: grant in IDLE, present address, then steer data beats.
    always_comb begin
        wr_state_d    = wr_state_q;
        wr_gnt_d      = wr_gnt_q;
        wr_ptr_d      = wr_ptr_q;
        awaddr_d      = awaddr_q;
        awlen_d       = awlen_q;
        m0_awready    = 1'b0;
        m1_awready    = 1'b0;
        m0_wready     = 1'b0;
        m1_wready     = 1'b0;
        m0_wlast      = 1'b0;
        m1_wlast      = 1'b0;
        axi_awvalid   = 1'b0;
        axi_awaddr    = {ADDR_WIDTH{1'b0}};
        axi_awlen     = {LEN_WIDTH{1'b0}};
        axi_awuser_id = 4'b0000;
        axi_awuser_ap = 1'b0;
        axi_wdata     = {DATA_WIDTH{1'b0}};
        axi_wstrb     = {STRB_WIDTH{1'b0}};
        case (wr_state_q)
            ST_IDLE: begin
                // resetn gating keeps awready low while reset is held
                if (resetn && (m0_awvalid || m1_awvalid)) begin
                    wr_gnt_d   = rr_pick(m0_awvalid, m1_awvalid, wr_ptr_q);
                    wr_state_d = ST_ADDR;
                    if (wr_gnt_d) begin
                        m1_awready = 1'b1;
                        awaddr_d   = m1_awaddr;
                        awlen_d    = m1_awlen;
                    end else begin
                        m0_awready = 1'b1;
                        awaddr_d   = m0_awaddr;
                        awlen_d    = m0_awlen;
                    end
                end else begin
                    wr_state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                axi_awvalid   = 1'b1;
                axi_awaddr    = awaddr_q;
                axi_awlen     = awlen_q;
                axi_awuser_id = {3'b000, wr_gnt_q};
                if (axi_awready) begin
                    wr_state_d = ST_DATA;
                end else begin
                    wr_state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (wr_gnt_q) begin
                    axi_wdata = m1_wdata;
                    axi_wstrb = m1_wstrb;
                    m1_wready = axi_wready;
                    m1_wlast  = axi_wusero_last;
                end else begin
                    axi_wdata = m0_wdata;
                    axi_wstrb = m0_wstrb;
                    m0_wready = axi_wready;
                    m0_wlast  = axi_wusero_last;
                end
                if (axi_wready && axi_wusero_last) begin
                    wr_state_d = ST_IDLE;
                    wr_ptr_d   = ~wr_gnt_q;
                end else begin
                    wr_state_d = ST_DATA;
                end
            end
            default: wr_state_d = ST_IDLE;
        endcase
    end

    // Read path: grant in IDLE, present address, then route response beats.
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_gnt_d      = rd_gnt_q;
        rd_ptr_d      = rd_ptr_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        rd_id_err_s   = 1'b0;
        m0_arready    = 1'b0;
        m1_arready    = 1'b0;
        m0_rvalid     = 1'b0;
        m1_rvalid     = 1'b0;
        m0_rlast      = 1'b0;
        m1_rlast      = 1'b0;
        m0_rdata      = {DATA_WIDTH{1'b0}};
        m1_rdata      = {DATA_WIDTH{1'b0}};
        axi_arvalid   = 1'b0;
        axi_araddr    = {ADDR_WIDTH{1'b0}};
        axi_arlen     = {LEN_WIDTH{1'b0}};
        axi_aruser_id = 4'b0000;
        axi_aruser_ap = 1'b0;
        case (rd_state_q)
            ST_IDLE: begin
                if (resetn && (m0_arvalid || m1_arvalid)) begin
                    rd_gnt_d   = rr_pick(m0_arvalid, m1_arvalid, rd_ptr_q);
                    rd_state_d = ST_ADDR;
                    if (rd_gnt_d) begin
                        m1_arready = 1'b1;
                        araddr_d   = m1_araddr;
                        arlen_d    = m1_arlen;
                    end else begin
                        m0_arready = 1'b1;
                        araddr_d   = m0_araddr;
                        arlen_d    = m0_arlen;
                    end
                end else begin
                    rd_state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                axi_arvalid   = 1'b1;
                axi_araddr    = araddr_q;
                axi_arlen     = arlen_q;
                axi_aruser_id = {3'b000, rd_gnt_q};
                if (axi_arready) begin
                    rd_state_d = ST_DATA;
                end else begin
                    rd_state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                m0_rdata = axi_rdata;
                m1_rdata = axi_rdata;
                if (rd_gnt_q) begin
                    m1_rvalid = axi_rvalid;
                    m1_rlast  = axi_rlast;
                end else begin
                    m0_rvalid = axi_rvalid;
                    m0_rlast  = axi_rlast;
                end
                // a beat tagged for the other master is still delivered, only flagged
                rd_id_err_s = axi_rvalid && (axi_rid[1:0] != {1'b0, rd_gnt_q});
                if (axi_rvalid && axi_rlast) begin
                    rd_state_d = ST_IDLE;
                    rd_ptr_d   = ~rd_gnt_q;
                end else begin
                    rd_state_d = ST_DATA;
                end
            end
            default: rd_state_d = ST_IDLE;
        endcase
    end

`ifdef ARB_BEAT_CHECK_EN
    logic [LEN_WIDTH-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

    // Beat counters: a burst must end exactly on beat len (zero based).
    always_comb begin
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        wr_beat_err_s = 1'b0;
        rd_beat_err_s = 1'b0;
        if (wr_state_q == ST_ADDR && axi_awready) begin
            wr_cnt_d = {LEN_WIDTH{1'b0}};
        end else if (wr_state_q == ST_DATA && axi_wready) begin
            wr_beat_err_s = axi_wusero_last != (wr_cnt_q == awlen_q);
            wr_cnt_d      = wr_cnt_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
        if (rd_state_q == ST_ADDR && axi_arready) begin
            rd_cnt_d = {LEN_WIDTH{1'b0}};
        end else if (rd_state_q == ST_DATA && axi_rvalid) begin
            rd_beat_err_s = axi_rlast != (rd_cnt_q == arlen_q);
            rd_cnt_d      = rd_cnt_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
    end

    // Beat counter registers.
    always_ff @(posedge ddrphy_clkin or negedge resetn) begin
        if (!resetn) begin
            wr_cnt_q <= {LEN_WIDTH{1'b0}};
            rd_cnt_q <= {LEN_WIDTH{1'b0}};
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end
`else
    assign wr_beat_err_s = 1'b0;
    assign rd_beat_err_s = 1'b0;
`endif

    // Sticky error accumulation; only reset clears it.
    assign err_d    = err_q | {rd_id_err_s | rd_beat_err_s, wr_beat_err_s};
    assign err_flag = err_q;

    // State, grant, pointer and latched request registers for both paths.
    always_ff @(posedge ddrphy_clkin or negedge resetn) begin
        if (!resetn) begin
            wr_state_q <= ST_IDLE;
            rd_state_q <= ST_IDLE;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            awaddr_q   <= {ADDR_WIDTH{1'b0}};
            araddr_q   <= {ADDR_WIDTH{1'b0}};
            awlen_q    <= {LEN_WIDTH{1'b0}};
            arlen_q    <= {LEN_WIDTH{1'b0}};
            err_q      <= 2'b00;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            awlen_q    <= awlen_d;
            arlen_q    <= arlen_d;
            err_q      <= err_d;
        end
    end

endmodule
